// File: rtl/csr_pkg.sv
// Machine-mode CSR definitions shared by the CSR file and the trap sequencer.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // mstatus field positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        PRIV_U = 2'd0,
        PRIV_S = 2'd1,
        PRIV_M = 2'd3
    } priv_e;

    typedef enum logic [2:0] {
        TS_IDLE,
        TS_DRAIN,
        TS_W_EPC,
        TS_W_CAUSE,
        TS_W_TVAL,
        TS_W_STATUS,
        TS_REDIRECT
    } trap_state_e;

    typedef enum logic {
        KIND_TRAP,
        KIND_MRET
    } trap_kind_e;

endpackage

// File: rtl/trap_sequencer.sv
// Sequences trap entry and mret return: drain the pipe, write the trap CSRs
// one per cycle, then redirect fetch and update the privilege mode.
module trap_sequencer
    import csr_pkg::*;
#(
    parameter int REG_WIDTH = 64,
    parameter int CSR       = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exc_valid,
    input  logic                 exc_is_int,
    input  logic [5:0]           exc_cause,
    input  logic [REG_WIDTH-1:0] exc_pc,
    input  logic [REG_WIDTH-1:0] exc_tval,
    input  logic                 mret_valid,
    input  logic                 pipe_empty,
    input  logic [REG_WIDTH-1:0] mstatus_csr,
    input  logic [REG_WIDTH-1:0] mtvec_csr,
    input  logic [REG_WIDTH-1:0] mepc_csr,
    output logic                 trap_busy,
    output logic                 flush,
    output logic                 csr_wr_valid,
    output logic [CSR-1:0]       csr_wr_addr,
    output logic [REG_WIDTH-1:0] csr_wr_data,
    output logic                 redirect_valid,
    output logic [REG_WIDTH-1:0] redirect_pc,
    output logic [1:0]           priv
);

    trap_state_e          state_q,  state_d;
    trap_kind_e           kind_q,   kind_d;
    logic                 is_int_q, is_int_d;
    logic [5:0]           cause_q,  cause_d;
    logic [REG_WIDTH-1:0] pc_q,     pc_d;
    logic [REG_WIDTH-1:0] tval_q,   tval_d;
    priv_e                priv_q,   priv_d;
    logic                 flush_q,  flush_d;

    logic [REG_WIDTH-1:0] mstatus_wr;
    logic [REG_WIDTH-1:0] tvec_base;
    logic [REG_WIDTH-1:0] vec_off;

    // Next-state: capture the request, walk the write sequence, update priv
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        is_int_d = is_int_q;
        cause_d  = cause_q;
        pc_d     = pc_q;
        tval_d   = tval_q;
        priv_d   = priv_q;
        flush_d  = 1'b0;
        case (state_q)
            TS_IDLE: begin
                // exception takes priority over a coincident mret
                if (exc_valid) begin
                    kind_d   = KIND_TRAP;
                    is_int_d = exc_is_int;
                    cause_d  = exc_cause;
                    pc_d     = exc_pc;
                    tval_d   = exc_tval;
                    state_d  = TS_DRAIN;
                    flush_d  = 1'b1;
                end else if (mret_valid) begin
                    kind_d  = KIND_MRET;
                    state_d = TS_DRAIN;
                    flush_d = 1'b1;
                end
            end
            TS_DRAIN: begin
                if (pipe_empty)
                    state_d = (kind_q == KIND_TRAP) ? TS_W_EPC : TS_W_STATUS;
            end
            TS_W_EPC:   state_d = TS_W_CAUSE;
            TS_W_CAUSE: state_d = TS_W_TVAL;
            TS_W_TVAL:  state_d = TS_W_STATUS;
            TS_W_STATUS: begin
                if (kind_q == KIND_TRAP)
                    priv_d = PRIV_M;
                else
                    priv_d = priv_e'(mstatus_csr[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
                state_d = TS_REDIRECT;
            end
            TS_REDIRECT: state_d = TS_IDLE;
            default:     state_d = TS_IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any sequence
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TS_IDLE;
            kind_q   <= KIND_TRAP;
            is_int_q <= 1'b0;
            cause_q  <= '0;
            pc_q     <= '0;
            tval_q   <= '0;
            priv_q   <= PRIV_M;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            is_int_q <= is_int_d;
            cause_q  <= cause_d;
            pc_q     <= pc_d;
            tval_q   <= tval_d;
            priv_q   <= priv_d;
            flush_q  <= flush_d;
        end
    end

    // mstatus rewrite and fetch target, built from the live CSR values
    always_comb begin
        mstatus_wr = mstatus_csr;
        if (kind_q == KIND_TRAP) begin
            mstatus_wr[MSTATUS_MPIE]                  = mstatus_csr[MSTATUS_MIE];
            mstatus_wr[MSTATUS_MIE]                   = 1'b0;
            mstatus_wr[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
        end else begin
            mstatus_wr[MSTATUS_MIE]                   = mstatus_csr[MSTATUS_MPIE];
            mstatus_wr[MSTATUS_MPIE]                  = 1'b1;
            mstatus_wr[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        end
        tvec_base = mtvec_csr & ~REG_WIDTH'(3);
        vec_off   = REG_WIDTH'({cause_q, 2'b00});
    end

    // Moore outputs decoded from the current state; idle values are zero
    always_comb begin
        csr_wr_valid   = 1'b0;
        csr_wr_addr    = '0;
        csr_wr_data    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (state_q)
            TS_W_EPC: begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = CSR'(CSR_MEPC);
                csr_wr_data  = pc_q & ~REG_WIDTH'(1);
            end
            TS_W_CAUSE: begin
                csr_wr_valid               = 1'b1;
                csr_wr_addr                = CSR'(CSR_MCAUSE);
                csr_wr_data[REG_WIDTH-1]   = is_int_q;
                csr_wr_data[5:0]           = cause_q;
            end
            TS_W_TVAL: begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = CSR'(CSR_MTVAL);
                csr_wr_data  = tval_q;
            end
            TS_W_STATUS: begin
                csr_wr_valid = 1'b1;
                csr_wr_addr  = CSR'(CSR_MSTATUS);
                csr_wr_data  = mstatus_wr;
            end
            TS_REDIRECT: begin
                redirect_valid = 1'b1;
                if (kind_q == KIND_MRET)
                    redirect_pc = mepc_csr & ~REG_WIDTH'(1);
                else if (mtvec_csr[1:0] == 2'b01 && is_int_q)
                    redirect_pc = tvec_base + vec_off;
                else
                    redirect_pc = tvec_base;
            end
            default: ;
        endcase
    end

    assign trap_busy = (state_q != TS_IDLE);
    assign flush     = flush_q;
    assign priv      = priv_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus random
// trap/mret traffic compared cycle by cycle against a transaction model.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        exc_valid, exc_is_int, mret_valid, pipe_empty;
    logic [5:0]  exc_cause;
    logic [63:0] exc_pc, exc_tval, mstatus_csr, mtvec_csr, mepc_csr;
    logic        trap_busy, flush, csr_wr_valid, redirect_valid;
    logic [11:0] csr_wr_addr;
    logic [63:0] csr_wr_data, redirect_pc;
    logic [1:0]  priv;

    int checks = 0;
    int failures = 0;
    int viol = 0;

    // model state and observations from the last transaction
    logic [1:0]  m_priv;
    logic [63:0] obs_redir;
    logic [63:0] obs_mcause;
    logic [63:0] obs_mstatus;
    int          obs_rk;

    trap_sequencer dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_is_int(exc_is_int), .exc_cause(exc_cause),
        .exc_pc(exc_pc), .exc_tval(exc_tval), .mret_valid(mret_valid),
        .pipe_empty(pipe_empty), .mstatus_csr(mstatus_csr), .mtvec_csr(mtvec_csr),
        .mepc_csr(mepc_csr), .trap_busy(trap_busy), .flush(flush),
        .csr_wr_valid(csr_wr_valid), .csr_wr_addr(csr_wr_addr),
        .csr_wr_data(csr_wr_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .priv(priv)
    );

    always #5 clk = ~clk;

    // requests must never be presented while the sequencer is busy
    always @(posedge clk) if (trap_busy && (exc_valid || mret_valid)) viol++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One transaction. rst_at>0 asserts reset after checking cycle rst_at.
    task automatic run_txn(input bit do_exc, input bit do_mret, input bit is_int,
                           input logic [5:0] cause, input logic [63:0] pc,
                           input logic [63:0] tval, input logic [63:0] mtvec,
                           input logic [63:0] mstatus, input logic [63:0] mepc,
                           input int d, input int rst_at);
        bit          trap = do_exc;
        int          wr0 = 2 + d;
        int          nwr = trap ? 4 : 1;
        int          rk = wr0 + nwr;
        logic [11:0] ea [4];
        logic [63:0] ed [4];
        logic [63:0] ms, tgt;
        logic [1:0]  newp;
        bit          in_wr;
        int          idx;

        // expected effects from the architectural rules
        ms = mstatus;
        if (trap) begin
            ms[7] = mstatus[3];
            ms[3] = 1'b0;
            ms[12:11] = m_priv;
            newp = 2'd3;
            tgt = mtvec & ~64'd3;
            if (mtvec[1:0] == 2'd1 && is_int) tgt = tgt + 64'(cause) * 4;
            ea[0] = 12'h341; ed[0] = pc & ~64'd1;
            ea[1] = 12'h342; ed[1] = {is_int, 57'd0, cause};
            ea[2] = 12'h343; ed[2] = tval;
            ea[3] = 12'h300; ed[3] = ms;
        end else begin
            ms[3] = mstatus[7];
            ms[7] = 1'b1;
            ms[12:11] = 2'd0;
            newp = mstatus[12:11];
            tgt = mepc & ~64'd1;
            ea[0] = 12'h300; ed[0] = ms;
            ea[1] = '0; ed[1] = '0; ea[2] = '0; ed[2] = '0; ea[3] = '0; ed[3] = '0;
        end

        @(negedge clk);
        mstatus_csr = mstatus; mtvec_csr = mtvec; mepc_csr = mepc;
        exc_valid = do_exc; mret_valid = do_mret; exc_is_int = is_int;
        exc_cause = cause; exc_pc = pc; exc_tval = tval;

        for (int k = 1; k <= rk + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin exc_valid = 1'b0; mret_valid = 1'b0; end
            in_wr = (k >= wr0) && (k < wr0 + nwr);
            idx = in_wr ? k - wr0 : 0;
            chk("busy", trap_busy, 64'(k <= rk));
            chk("flush", flush, 64'(k == 1));
            chk("wr_valid", csr_wr_valid, 64'(in_wr));
            chk("wr_addr", csr_wr_addr, in_wr ? ea[idx] : 64'd0);
            chk("wr_data", csr_wr_data, in_wr ? ed[idx] : 64'd0);
            chk("redir_valid", redirect_valid, 64'(k == rk));
            if (k == rk) begin
                chk("redir_pc", redirect_pc, tgt);
                obs_redir = redirect_pc;
                obs_rk = k;
            end
            if (csr_wr_valid && csr_wr_addr == 12'h342) obs_mcause = csr_wr_data;
            if (csr_wr_valid && csr_wr_addr == 12'h300) obs_mstatus = csr_wr_data;
            chk("priv", priv, (k >= rk) ? newp : m_priv);
            pipe_empty = (k > d);
            if (k == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                m_priv = 2'd3;
                for (int j = 0; j < 4; j++) begin
                    chk("rst_busy", trap_busy, 0);
                    chk("rst_wr_valid", csr_wr_valid, 0);
                    chk("rst_redir", redirect_valid, 0);
                    chk("rst_priv", priv, 64'd3);
                    @(negedge clk);
                end
                return;
            end
        end
        m_priv = newp;
    endtask

    initial begin
        reset = 1'b1; exc_valid = 0; mret_valid = 0; exc_is_int = 0; exc_cause = 0;
        exc_pc = 0; exc_tval = 0; pipe_empty = 1; mstatus_csr = 0; mtvec_csr = 0;
        mepc_csr = 0; m_priv = 2'd3; obs_redir = 0; obs_mcause = 0; obs_mstatus = 0;
        obs_rk = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_priv", priv, 64'd3);
        chk("reset_busy", trap_busy, 0);
        chk("reset_wr_valid", csr_wr_valid, 0);
        chk("reset_redir", redirect_valid, 0);
        reset = 1'b0;

        // mret back to U: MPP=0, MPIE=1, MIE=0
        run_txn(0, 1, 0, 6'd0, 64'd0, 64'd0, 64'h8000_0100, 64'h80, 64'h8000_2001, 0, -1);
        chk("mret_mstatus", obs_mstatus, 64'h88);
        chk("mret_redir", obs_redir, 64'h8000_2000);
        chk("mret_rk", obs_rk, 3);
        chk("mret_priv", priv, 64'd0);

        // synchronous exception from U with MIE=1
        run_txn(1, 0, 0, 6'd8, 64'h8000_1004, 64'd0, 64'h8000_0100, 64'h8, 64'd0, 0, -1);
        chk("sync_mstatus", obs_mstatus, 64'h80);
        chk("sync_mcause", obs_mcause, 64'd8);
        chk("sync_redir", obs_redir, 64'h8000_0100);
        chk("sync_rk", obs_rk, 6);
        chk("sync_priv", priv, 64'd3);

        // vectored interrupt
        run_txn(1, 0, 1, 6'd7, 64'h8000_3000, 64'd0, 64'h8000_0101, 64'h8, 64'd0, 0, -1);
        chk("vec_mcause", obs_mcause, 64'h8000_0000_0000_0007);
        chk("vec_redir", obs_redir, 64'h8000_011C);

        // drain stall of 5 cycles
        run_txn(1, 0, 0, 6'd2, 64'h8000_4000, 64'h1234, 64'h8000_0200, 64'h0, 64'd0, 5, -1);
        chk("stall_rk", obs_rk, 11);

        // exception and mret together: trap sequence only
        run_txn(1, 1, 0, 6'd5, 64'h8000_5002, 64'hdead, 64'h8000_0300, 64'h1888, 64'h9000_0000, 0, -1);
        chk("coll_redir", obs_redir, 64'h8000_0300);

        // reset during W_CAUSE (cycle 3 with no stall)
        run_txn(1, 0, 0, 6'd3, 64'h8000_6000, 64'h55, 64'h8000_0400, 64'h8, 64'd0, 0, 3);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            bit mr = ($urandom_range(0, 3) == 0);
            logic [63:0] mt = {$urandom, $urandom};
            run_txn(!mr, mr, 1'($urandom), 6'($urandom), {$urandom, $urandom},
                    {$urandom, $urandom}, mt, {$urandom, $urandom},
                    {$urandom, $urandom}, $urandom_range(0, 3), -1);
        end

        chk("no_req_busy", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Initiator side of the machine-mode CSR interface. It sequences trap entry (exception/interrupt) and `mret` return for the in-order pipeline. It accepts a committed trap or `mret` request from writeback, flushes and drains the pipeline, and issues full-width writes to `mepc`/`mcause`/`mtval`/`mstatus` through the CSR file's write port. It then redirects fetch to the `mtvec` or `mepc` target and tracks the current privilege mode.

## Interface
- REG_WIDTH, 64, CSR data width
- CSR, 12, CSR address width
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- exc_valid  in  1  exception/interrupt committed at writeback (1-cycle pulse)
- exc_is_int  in  1  request is an interrupt
- exc_cause  in  6  cause code
- exc_pc  in  REG_WIDTH  PC of trapping instruction
- exc_tval  in  REG_WIDTH  trap value
- mret_valid  in  1  `mret` committed (1-cycle pulse)
- pipe_empty  in  1  no in-flight instructions or memory ops
- mstatus_csr, mtvec_csr, mepc_csr  in  REG_WIDTH  current CSR values
- trap_busy  out  1  stall fetch/commit
- flush  out  1  squash younger instructions
- csr_wr_valid  out  1  CSR write strobe
- csr_wr_addr  out  CSR  CSR write address
- csr_wr_data  out  REG_WIDTH  CSR write value (full overwrite)
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  REG_WIDTH  redirect target
- priv  out  2  current privilege (U=0, S=1, M=3)

## Operation
- States: IDLE, DRAIN, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT.
- **IDLE + exc_valid.**
  - Capture cause, is_int, pc and tval into registers.
  - Set the kind to TRAP and go to DRAIN.
  - exc_valid wins over a simultaneous mret_valid.
- **IDLE + mret_valid.** Set the kind to MRET and go to DRAIN.
- **Requests outside IDLE.** Ignored; the pipeline is stalled, and the bench asserts that none arrive.
- **DRAIN.** Hold while pipe_empty=0. When pipe_empty=1, go to W_EPC (TRAP) or W_STATUS (MRET).
- **W_EPC.** Write `mepc` = captured pc with bit 0 cleared.
- **W_CAUSE.** Write `mcause` = {is_int, zero-fill, cause[5:0]}; bit REG_WIDTH-1 is the interrupt flag.
- **W_TVAL.** Write `mtval` = captured tval.
- **W_STATUS on TRAP.**
  - `mstatus` = mstatus_csr with MPIE←MIE, MIE←0, MPP←priv.
  - priv←M.
- **W_STATUS on MRET.**
  - `mstatus` = mstatus_csr with MIE←MPIE, MPIE←1, MPP←U.
  - priv←old MPP.
- **REDIRECT.** Pulse redirect_valid for one cycle, then go to IDLE.
  - TRAP, normal: target = mtvec_csr & ~3.
  - TRAP, vectored (mtvec[1:0]=1 and is_int): target = (mtvec & ~3) + 4·cause.
  - MRET: target = mepc_csr with bit 0 cleared.
- **Output rules.**
  - csr_wr_valid is high only in the W_* states.
  - csr_wr_addr and csr_wr_data are zero outside the W_* states.
  - trap_busy = (state≠IDLE).
  - flush is high only in the first DRAIN cycle.
- **CSR port.** The CSR file accepts a write every cycle. No instruction CSR op commits while trap_busy=1, so the two writers never conflict.
- **Reset, including mid-sequence.** State→IDLE, priv=M, all other outputs 0, captured registers cleared. No further writes are issued.

## Timing
- Request sampled at edge T. DRAIN is occupied from T+1; flush=1 at T+1.
- With pipe_empty=1 at T+1:
  - TRAP: writes at T+2 (mepc), T+3 (mcause), T+4 (mtval), T+5 (mstatus); redirect at T+6.
  - MRET: mstatus write at T+2; redirect at T+3.
- Each cycle pipe_empty stays low delays every later event by one cycle.
- priv changes at the edge ending W_STATUS, so the new value is visible in the REDIRECT cycle.
- Targets are computed combinationally from the CSR inputs in REDIRECT. All earlier writes have landed by then.

## Structure
- `csr_pkg` (shared with the CSR file): CSR address constants (mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343), mstatus bit positions (MIE 3, MPIE 7, MPP 12:11), privilege enum, trap-state enum.
- Single module, no sub-modules.

## Test plan
- **Reset.** Assert reset for 2 cycles → priv=3, trap_busy=0, csr_wr_valid=0, redirect_valid=0.
- **Synchronous exception.**
  - Stimulus: exc_valid, cause=8, pc=0x8000_1004, tval=0, mtvec=0x8000_0100, mstatus.MIE=1, priv=0, pipe_empty=1.
  - Writes: mepc=0x8000_1004 at T+2, mcause=8 at T+3, mtval=0 at T+4, mstatus with MIE=0, MPIE=1, MPP=0 at T+5.
  - Redirect 0x8000_0100 at T+6; priv=3.
- **Vectored interrupt.** mtvec=0x8000_0101, is_int=1, cause=7 → mcause=0x8000_0000_0000_0007, redirect 0x8000_011C.
- **mret.** mstatus MPP=0, MPIE=1; mepc=0x8000_2001 → mstatus write with MIE=1, MPIE=1, MPP=0 at T+2; redirect 0x8000_2000 at T+3; priv=0.
- **Drain stall.** pipe_empty held low for 5 cycles after a trap → flush only at T+1, no writes until pipe_empty rises, redirect at T+11.
- **Collision and mid-sequence reset.**
  - exc_valid and mret_valid in the same cycle → TRAP sequence only.
  - reset asserted during W_CAUSE → IDLE next cycle, no mtval/mstatus writes, no redirect.
